// File: rtl/c_handshake_tx.sv
// c_handshake_tx: clocked valid/ready source to 4-phase bundled-data
// request/acknowledge transmitter with ack synchronizer, per-phase timeout
// and completed-transfer counter.
module c_handshake_tx #(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,   // must be at least 2
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] data_o,
    output logic              req_o,
    input  logic              ack_i,
    input  logic              clear_err,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  xfer_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    // Value of the counter on the last permitted cycle of a phase.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_HI,
        S_WAIT_LO,
        S_ERR
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic                r_req,     w_req_nxt;
    logic [DATA_W-1:0]   r_data,    w_data_nxt;
    logic                r_to_err,  w_to_err_nxt;
    logic [CNT_W-1:0]    r_xfer,    w_xfer_nxt;
    logic [TO_W-1:0]     r_to_cnt,  w_to_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                w_ack_s;
    logic                w_in_ready;

    // Synchronize the asynchronous acknowledge into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign w_ack_s    = r_sync[SYNC_STAGES-1];
    // A new word is only taken once the previous acknowledge has returned to zero.
    assign w_in_ready = (r_state == S_IDLE) && !w_ack_s;

    // State register and all handshake-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_data   <= '0;
            r_to_err <= 1'b0;
            r_xfer   <= '0;
            r_to_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update
            // from the same pre-edge values, regardless of statement order.
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_data   <= w_data_nxt;
            r_to_err <= w_to_err_nxt;
            r_xfer   <= w_xfer_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // Next-state and next-register logic for the 4-phase handshake.
    always_comb begin
        // NOTE: every output of this block gets a hold value first so that no
        // path through the case statement can infer a latch.
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_data_nxt   = r_data;
        w_to_err_nxt = r_to_err;
        w_xfer_nxt   = r_xfer;
        w_to_cnt_nxt = r_to_cnt;

        case (r_state)
            S_IDLE: begin
                if (in_valid && w_in_ready) begin
                    w_data_nxt  = in_data;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                // One cycle of data setup before the request edge.
                w_req_nxt   = 1'b1;
                w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_WAIT_LO;
                end else if (r_to_cnt == TO_LAST) begin
                    w_req_nxt    = 1'b0;
                    w_to_err_nxt = 1'b1;
                    w_state_nxt  = S_ERR;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!w_ack_s) begin
                    w_xfer_nxt  = r_xfer + CNT_W'(1);
                    w_state_nxt = S_IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_to_err_nxt = 1'b1;
                    w_state_nxt  = S_ERR;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_ERR: begin
                w_req_nxt = 1'b0;
                // Leaving ERR with ack still high would break the next handshake.
                if (clear_err && !w_ack_s) begin
                    w_to_err_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Each phase gets its own full timeout budget.
        if (w_state_nxt != r_state) begin
            w_to_cnt_nxt = '0;
        end
    end

    assign in_ready    = w_in_ready;
    assign data_o      = r_data;
    assign req_o       = r_req;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_to_err;
    assign xfer_count  = r_xfer;

endmodule

// File: tb/tb_c_handshake_tx.sv
// Testbench for c_handshake_tx: directed stimulus, queue-based scoreboard
// with an independent monitor, plus directed timing and error-path checks.
module tb_c_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       clear_err;
    logic       ack_i;

    logic       in_ready, req_o, busy, timeout_err;
    logic [3:0] data_o;
    logic [7:0] xfer_count;

    logic       in_ready2, req_o2, busy2, timeout_err2;
    logic [3:0] data_o2;
    logic [1:0] xfer_count2;

    // Acknowledge responder: 0 = driven by hand, 1 = instant, 2 = one cycle late.
    int         mode;
    logic       ack_man;
    logic       ack_dly = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_cnt = 0;

    logic [3:0] exp_data_q [$];
    logic [7:0] exp_cnt_q  [$];
    logic [1:0] exp_cnt2_q [$];

    always #5 clk = ~clk;

    assign ack_i = (mode == 1) ? req_o : (mode == 2) ? ack_dly : ack_man;

    always @(posedge clk) ack_dly <= req_o;

    c_handshake_tx #(.DATA_W(4), .SYNC_STAGES(2), .TIMEOUT(255), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .data_o(data_o), .req_o(req_o), .ack_i(ack_i),
        .clear_err(clear_err), .busy(busy), .timeout_err(timeout_err),
        .xfer_count(xfer_count)
    );

    c_handshake_tx #(.DATA_W(4), .SYNC_STAGES(2), .TIMEOUT(255), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .data_o(data_o2), .req_o(req_o2), .ack_i(ack_i),
        .clear_err(clear_err), .busy(busy2), .timeout_err(timeout_err2),
        .xfer_count(xfer_count2)
    );

    // Independent model of the synchronized acknowledge.
    logic [1:0] m_sync;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_sync <= 2'b00;
        else        m_sync <= {m_sync[0], ack_i};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations when the DUT presents a request or a new count.
    logic       prev_req = 1'b0, prev_busy = 1'b0;
    logic [3:0] prev_data = '0;
    logic [7:0] prev_cnt = '0;
    logic [1:0] prev_cnt2 = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_o && !prev_req) begin
                check("req_rise_ack_s_low", {31'd0, m_sync[1]}, 32'd0);
                if (exp_data_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
                else check("data_o", {28'd0, data_o}, {28'd0, exp_data_q.pop_front()});
            end
            if (xfer_count != prev_cnt) begin
                if (exp_cnt_q.size() == 0) check("unexpected_count", {24'd0, xfer_count}, {24'd0, prev_cnt});
                else check("xfer_count", {24'd0, xfer_count}, {24'd0, exp_cnt_q.pop_front()});
            end
            if (xfer_count2 != prev_cnt2) begin
                if (exp_cnt2_q.size() == 0) check("unexpected_count2", {30'd0, xfer_count2}, {30'd0, prev_cnt2});
                else check("xfer_count2", {30'd0, xfer_count2}, {30'd0, exp_cnt2_q.pop_front()});
            end
            if (prev_busy) check("data_o_stable", {28'd0, data_o}, {28'd0, prev_data});
        end
        prev_req  <= req_o;
        prev_busy <= busy;
        prev_data <= data_o;
        prev_cnt  <= xfer_count;
        prev_cnt2 <= xfer_count2;
    end

    function automatic logic sig_val(input int sel);
        case (sel)
            0:       return req_o;
            1:       return busy;
            2:       return timeout_err;
            3:       return in_ready;
            default: return 1'b0;
        endcase
    endfunction

    // Counts falling edges until the selected output reaches val (bounded).
    task automatic wait_sig(input int sel, input logic val, input int max_cyc, output int k);
        k = 0;
        while (sig_val(sel) !== val && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic push_exp(input logic [3:0] d, input bit done);
        exp_data_q.push_back(d);
        if (done) begin
            model_cnt++;
            exp_cnt_q.push_back(8'(model_cnt % 256));
            exp_cnt2_q.push_back(2'(model_cnt % 4));
        end
    endtask

    task automatic send(input logic [3:0] d, input bit done);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        push_exp(d, done);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, tot;
        rst_n = 1'b0; in_valid = 1'b1; in_data = 4'hA;
        clear_err = 1'b0; ack_man = 1'b0; mode = 1;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_req", {31'd0, req_o}, 32'd0);
        check("rst_data", {28'd0, data_o}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, timeout_err}, 32'd0);
        check("rst_count", {24'd0, xfer_count}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        // Test 1: accept at the first edge, instant ack, minimum handshake timing.
        rst_n = 1'b1;
        @(posedge clk);
        push_exp(4'hA, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_data_latched", {28'd0, data_o}, 32'hA);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_req_setup", {31'd0, req_o}, 32'd0);
        check("t1_ready_low", {31'd0, in_ready}, 32'd0);
        wait_sig(0, 1'b1, 20, k); tot = k;
        check("t1_req_rise_cyc", tot, 32'd1);
        wait_sig(0, 1'b0, 20, k); tot += k;
        check("t1_req_fall_cyc", tot, 32'd4);
        wait_sig(1, 1'b0, 20, k); tot += k;
        check("t1_idle_cyc", tot, 32'd7);
        check("t1_ready_again", {31'd0, in_ready}, 32'd1);
        check("t1_count", {24'd0, xfer_count}, 32'd1);

        // Test 2: back-to-back words with a one-cycle-late responder.
        mode = 2;
        send(4'h3, 1'b1);
        send(4'hC, 1'b1);
        send(4'h5, 1'b1);
        send(4'h9, 1'b1);
        wait_sig(1, 1'b0, 100, k);
        repeat (2) @(negedge clk);
        check("t2_idle", {31'd0, busy}, 32'd0);
        check("t2_count", {24'd0, xfer_count}, 32'd5);
        check("t2_count_wrap", {30'd0, xfer_count2}, 32'd1);
        check("t2_queue_empty", exp_data_q.size(), 32'd0);

        // Test 3: ack never rises; timeout in WAIT_HI.
        mode = 0; ack_man = 1'b0;
        send(4'h6, 1'b0);
        wait_sig(0, 1'b1, 20, k); tot = k;
        wait_sig(2, 1'b1, 400, k); tot += k;
        check("t3_timeout_cyc", tot, 32'd256);
        check("t3_req_low", {31'd0, req_o}, 32'd0);
        check("t3_busy_err", {31'd0, busy}, 32'd1);
        check("t3_ready_err", {31'd0, in_ready}, 32'd0);
        pulse_clear();
        check("t3_clear_idle", {31'd0, busy}, 32'd0);
        check("t3_clear_err", {31'd0, timeout_err}, 32'd0);
        check("t3_clear_ready", {31'd0, in_ready}, 32'd1);

        // Test 4: ack stuck high; timeout in WAIT_LO and guarded clear.
        send(4'h2, 1'b0);
        wait_sig(0, 1'b1, 20, k);
        ack_man = 1'b1;
        wait_sig(0, 1'b0, 20, k);
        check("t4_req_fall_cyc", k, 32'd3);
        wait_sig(2, 1'b1, 400, k);
        check("t4_timeout_cyc", k, 32'd255);
        pulse_clear();
        check("t4_clear_ignored_busy", {31'd0, busy}, 32'd1);
        check("t4_clear_ignored_err", {31'd0, timeout_err}, 32'd1);
        ack_man = 1'b0;
        repeat (3) @(negedge clk);
        pulse_clear();
        check("t4_clear_idle", {31'd0, busy}, 32'd0);
        check("t4_clear_err", {31'd0, timeout_err}, 32'd0);
        check("t4_clear_ready", {31'd0, in_ready}, 32'd1);

        // Test 5: reset while in WAIT_HI with ack high.
        send(4'h7, 1'b0);
        wait_sig(0, 1'b1, 20, k);
        ack_man = 1'b1;
        @(negedge clk);
        check("t5_req_before_rst", {31'd0, req_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_req_async", {31'd0, req_o}, 32'd0);
        check("t5_busy_async", {31'd0, busy}, 32'd0);
        check("t5_count_async", {24'd0, xfer_count}, 32'd0);
        exp_data_q.delete(); exp_cnt_q.delete(); exp_cnt2_q.delete();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_ready_held", {31'd0, in_ready}, 32'd0);
        check("t5_idle", {31'd0, busy}, 32'd0);
        ack_man = 1'b0;
        wait_sig(3, 1'b1, 20, k);
        check("t5_ready_cyc", k, 32'd2);

        // Test 6: normal operation resumes after reset.
        mode = 1;
        send(4'hE, 1'b1);
        wait_sig(1, 1'b0, 50, k);
        @(negedge clk);
        check("t6_count", {24'd0, xfer_count}, 32'd1);
        check("t6_count2", {30'd0, xfer_count2}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/c_handshake_tx.md
Name: c_handshake_tx

Overview:
- Synchronous-to-asynchronous 4-phase bundled-data transmitter. It drives requests into the Muller C-element pipeline stage and consumes that stage's acknowledge.
- Takes words from a clocked valid/ready source, presents them on data_o/req_o, and completes the return-to-zero handshake on ack_i.
- Sits on the user-project side, in front of the async C-element pipeline.
- The ack input is asynchronous to clk and is synchronized internally.

Parameters:
- DATA_W, 4, width of the bundled data word.
- SYNC_STAGES, 2, flop stages on ack_i (minimum 2).
- TIMEOUT, 255, maximum cycles to wait in either ack phase before declaring error. Counter width is clog2(TIMEOUT+1).
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  Single clock; all state changes on its rising edge.
- rst_n  input  1  Asynchronous assert, active-low reset.
- in_valid  input  1  Source has a word.
- in_ready  output  1  Block accepts a word this cycle.
- in_data  input  DATA_W  Word from source.
- data_o  output  DATA_W  Bundled data to the async stage.
- req_o  output  1  4-phase request to the async stage.
- ack_i  input  1  4-phase acknowledge from the C-element (asynchronous).
- clear_err  input  1  Single-cycle pulse that clears the error state.
- busy  output  1  Handshake in progress (state not IDLE).
- timeout_err  output  1  Sticky timeout flag.
- xfer_count  output  CNT_W  Completed handshakes, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, req_o=0, data_o=0, busy=0, timeout_err=0, xfer_count=0, sync chain=0, timeout counter=0.
- ack_s is ack_i after SYNC_STAGES flops. All decisions use ack_s only.
- in_ready = (state==IDLE) && (ack_s==0). This is combinational from registered state.
- IDLE:
  - On in_valid && in_ready, latch in_data into data_o and go to SETUP.
  - data_o holds its value in all other cycles.
- SETUP: exactly one cycle, giving bundled-data setup margin. Set req_o=1 and go to WAIT_HI. req_o is therefore first high one cycle after the accept edge.
- WAIT_HI:
  - If ack_s==1: req_o<=0 and go to WAIT_LO.
  - Otherwise increment the timeout counter.
  - Counter reaching TIMEOUT: go to ERR, req_o<=0, timeout_err<=1.
- WAIT_LO:
  - If ack_s==0: go to IDLE and increment xfer_count.
  - Otherwise increment the timeout counter; reaching TIMEOUT goes to ERR with timeout_err<=1.
- The timeout counter clears on every state change.
- xfer_count wraps from 2^CNT_W-1 to 0.
- ERR:
  - req_o=0 and in_ready=0.
  - clear_err with ack_s==0: go to IDLE and clear timeout_err.
  - clear_err with ack_s==1: ignored; remain in ERR.
  - clear_err outside ERR: no effect.
- data_o is stable from the accept edge until the next accept. It never changes while req_o=1 or during WAIT_LO.
- req_o is glitch-free: driven directly from a flop.
- busy = (state != IDLE). busy is 1 in ERR.
- Minimum handshake with instant ack: accept edge N, req_o rises at N+1, req_o falls at N+1+SYNC_STAGES+1, IDLE at N+2*SYNC_STAGES+3.
- Reset mid-handshake: req_o drops immediately (asynchronous). After release, the block waits in IDLE with in_ready=0 until ack_s==0.
- in_valid deasserted while busy: no effect. Back-to-back words are accepted only after returning to IDLE.

Test Plan:
- Reset release with ack_i=0, in_valid=1, in_data=4'hA: accept at edge 1. data_o=A, req_o=1 at edge 2. A responder returns ack 1 cycle after req; expect req_o=0 after ack_s rises, xfer_count=1, in_ready=1 again. Total cycle count must equal the formula above.
- Send 4'h3, 4'hC, 4'h5 back-to-back with an auto-responder: xfer_count=3. data_o never changes while req_o=1 or during WAIT_LO (assertion). req_o never rises with ack_s=1.
- ack_i stuck 0 after request, TIMEOUT=255: timeout_err=1 and req_o=0 after 255 WAIT_HI cycles. A clear_err pulse returns to IDLE and timeout_err=0.
- ack_i stuck 1 after rising: ERR from WAIT_LO after 255 cycles. clear_err while ack_i=1 keeps ERR. ack_i=0 followed by clear_err returns to IDLE.
- CNT_W=2, 5 transfers: xfer_count sequence 1,2,3,0,1.
- Assert rst_n=0 while in WAIT_HI with ack_i=1: req_o=0 immediately. After release, in_ready=0 until ack_s=0, then 1.
